ts_sequence_tracker: RTL

Receive-side ordered-set classifier and consecutive-TS tracker for the Gen1/Gen2 (8b/10b) path. It sits directly downstream of the ordered-set decoder and consumes one COM-aligned 16-symbol ordered set per valid beat. It classifies each set as TS1, TS2, SKP or malformed, latches the training fields, and counts consecutive identical TS1/TS2 sets. The LTSSM uses its "N consecutive" flags for Polling/Configuration transitions.

---
 rtl/ts_sequence_tracker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ts_sequence_tracker.sv
// Receive-side ordered-set classifier and consecutive TS1/TS2 tracker (Gen1/Gen2 path).
// One COM-aligned 16-symbol ordered set is consumed per valid beat; all outputs registered.
module ts_sequence_tracker #(
    parameter int unsigned COUNT_WIDTH  = 5,
    parameter int unsigned TARGET_COUNT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_os_valid,
    input  logic [127:0]           i_os_data,
    input  logic                   i_clear_count,
    output logic [1:0]             o_os_type,
    output logic [COUNT_WIDTH-1:0] o_ts_count,
    output logic                   o_ts1_seen,
    output logic                   o_ts2_seen,
    output logic [7:0]             o_link_num,
    output logic [7:0]             o_lane_num,
    output logic [7:0]             o_n_fts,
    output logic [7:0]             o_rate_id,
    output logic [7:0]             o_train_ctl,
    output logic                   o_os_update,
    output logic                   o_os_error
);

    localparam int unsigned SYM_W    = 8;
    localparam int unsigned NUM_SYM  = 16;
    localparam int unsigned FIELDS_W = 5 * SYM_W;

    localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
    localparam logic [SYM_W-1:0] SYM_TS1 = 8'h4A;
    localparam logic [SYM_W-1:0] SYM_TS2 = 8'h45;
    localparam logic [SYM_W-1:0] SYM_SKP = 8'h1C;

    localparam logic [1:0] TYPE_NONE = 2'd0;
    localparam logic [1:0] TYPE_TS1  = 2'd1;
    localparam logic [1:0] TYPE_TS2  = 2'd2;
    localparam logic [1:0] TYPE_SKP  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_TARGET = COUNT_WIDTH'(TARGET_COUNT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_track_type;
    logic [1:0]             w_track_type_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic [FIELDS_W-1:0]    r_fields;
    logic [FIELDS_W-1:0]    w_fields_nxt;
    logic [1:0]             r_os_type;
    logic [1:0]             w_os_type_nxt;
    logic                   r_update;
    logic                   w_update_nxt;
    logic                   r_error;
    logic                   w_error_nxt;
    logic                   r_ts1_seen;
    logic                   r_ts2_seen;
    logic                   w_ts1_seen_nxt;
    logic                   w_ts2_seen_nxt;

    logic [SYM_W-1:0]       w_sym [NUM_SYM];
    logic                   w_tail_ts1;
    logic                   w_tail_ts2;
    logic                   w_is_skp;
    logic                   w_is_ts;
    logic                   w_malformed;
    logic [1:0]             w_cls_type;
    logic [FIELDS_W-1:0]    w_fields_in;

    // Split the beat into symbols and classify it as TS1/TS2/SKP/malformed.
    always_comb begin
        w_tail_ts1 = 1'b1;
        w_tail_ts2 = 1'b1;
        for (int k = 0; k < int'(NUM_SYM); k++) begin
            w_sym[k] = i_os_data[SYM_W*k +: SYM_W];
        end
        for (int k = 6; k < int'(NUM_SYM); k++) begin
            if (w_sym[k] != SYM_TS1) w_tail_ts1 = 1'b0;
            if (w_sym[k] != SYM_TS2) w_tail_ts2 = 1'b0;
        end
        w_fields_in = i_os_data[SYM_W +: FIELDS_W];
        w_is_skp    = 1'b0;
        w_is_ts     = 1'b0;
        w_cls_type  = TYPE_NONE;
        if (w_sym[0] == SYM_COM) begin
            if (w_tail_ts1) begin
                w_is_ts    = 1'b1;
                w_cls_type = TYPE_TS1;
            end else if (w_tail_ts2) begin
                w_is_ts    = 1'b1;
                w_cls_type = TYPE_TS2;
            end else if ((w_sym[1] == SYM_SKP) && (w_sym[2] == SYM_SKP) && (w_sym[3] == SYM_SKP)) begin
                w_is_skp   = 1'b1;
                w_cls_type = TYPE_SKP;
            end
        end
        w_malformed = !(w_is_ts || w_is_skp);
    end

    // Next-state and next-output logic; clearCount beats any set on the same beat.
    always_comb begin
        w_state_nxt      = r_state;
        w_track_type_nxt = r_track_type;
        w_count_nxt      = r_count;
        w_fields_nxt     = r_fields;
        w_os_type_nxt    = r_os_type;
        w_update_nxt     = 1'b0;
        w_error_nxt      = 1'b0;

        if (i_clear_count) begin
            w_count_nxt   = '0;
            w_os_type_nxt = TYPE_NONE;
            w_state_nxt   = S_IDLE;
        end else if (i_os_valid) begin
            if (w_malformed) begin
                w_error_nxt   = 1'b1;
                w_count_nxt   = '0;
                w_os_type_nxt = TYPE_NONE;
                w_state_nxt   = S_IDLE;
            end else if (w_is_skp) begin
                w_os_type_nxt = TYPE_SKP;
                w_update_nxt  = 1'b1;
            end else begin
                w_update_nxt     = 1'b1;
                w_os_type_nxt    = w_cls_type;
                w_track_type_nxt = w_cls_type;
                w_fields_nxt     = w_fields_in;
                w_state_nxt      = S_TRACK;
                if ((r_state == S_TRACK) && (w_cls_type == r_track_type) && (w_fields_in == r_fields)) begin
                    w_count_nxt = (r_count == COUNT_MAX) ? r_count : r_count + COUNT_ONE;
                end else begin
                    w_count_nxt = COUNT_ONE;
                end
            end
        end

        w_ts1_seen_nxt = (w_count_nxt >= COUNT_TARGET) && (w_track_type_nxt == TYPE_TS1);
        w_ts2_seen_nxt = (w_count_nxt >= COUNT_TARGET) && (w_track_type_nxt == TYPE_TS2);
    end

    // Tracking FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Count, training fields and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_track_type <= TYPE_NONE;
            r_count      <= '0;
            r_fields     <= '0;
            r_os_type    <= TYPE_NONE;
            r_update     <= 1'b0;
            r_error      <= 1'b0;
            r_ts1_seen   <= 1'b0;
            r_ts2_seen   <= 1'b0;
        end else begin
            r_track_type <= w_track_type_nxt;
            r_count      <= w_count_nxt;
            r_fields     <= w_fields_nxt;
            r_os_type    <= w_os_type_nxt;
            r_update     <= w_update_nxt;
            r_error      <= w_error_nxt;
            r_ts1_seen   <= w_ts1_seen_nxt;
            r_ts2_seen   <= w_ts2_seen_nxt;
        end
    end

    assign o_os_type   = r_os_type;
    assign o_ts_count  = r_count;
    assign o_ts1_seen  = r_ts1_seen;
    assign o_ts2_seen  = r_ts2_seen;
    assign o_link_num  = r_fields[0*SYM_W +: SYM_W];
    assign o_lane_num  = r_fields[1*SYM_W +: SYM_W];
    assign o_n_fts     = r_fields[2*SYM_W +: SYM_W];
    assign o_rate_id   = r_fields[3*SYM_W +: SYM_W];
    assign o_train_ctl = r_fields[4*SYM_W +: SYM_W];
    assign o_os_update = r_update;
    assign o_os_error  = r_error;

endmodule
